pdm_decimator: RTL and testbench



---
 rtl/pdm_decimator.sv | 109 ++++++++++
 tb/tb_pdm_decimator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - 3rd-order CIC decimator: 1-bit PDM stream to signed PCM
module pdm_decimator #(
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pdm_in,
    input  logic                 pdm_en,
    output logic [OUT_WIDTH-1:0] pcm_out,
    output logic                 pcm_valid,
    output logic                 settled
);

    // Filter gain is R^3 = 2^(3*DECIM_LOG2); two extra bits hold the sign and the +full-scale value.
    localparam int W     = 3 * DECIM_LOG2 + 2;
    localparam int SHIFT = 3 * DECIM_LOG2 - (OUT_WIDTH - 1);
    localparam int MAXV  = (2 ** (OUT_WIDTH - 1)) - 1;

    localparam logic signed [W-1:0] S_MAX = W'(MAXV);
    localparam logic signed [W-1:0] S_MIN = W'(-MAXV - 1);

    logic signed [W-1:0]     x_s;
    logic signed [W-1:0]     i1_q, i2_q, i3_q;
    logic signed [W-1:0]     i1_d, i2_d, i3_d;
    logic signed [W-1:0]     d1_q, d2_q, d3_q;
    logic signed [W-1:0]     c1_d, c2_d, c3_d;
    logic signed [W-1:0]     s_d;
    logic [OUT_WIDTH-1:0]    sat_d;
    logic [DECIM_LOG2-1:0]   cnt_q;
    logic [1:0]              warm_q;
    logic                    tick;
    logic [OUT_WIDTH-1:0]    pcm_q;
    logic                    pcm_valid_q;
    logic                    settled_q;

    // Integrator chain, comb chain and output scaling, all evaluated within the strobe cycle.
    always_comb begin
        x_s  = pdm_in ? W'(1) : {W{1'b1}};
        i1_d = i1_q + x_s;
        i2_d = i2_q + i1_d;
        i3_d = i3_q + i2_d;
        tick = pdm_en && (cnt_q == {DECIM_LOG2{1'b1}});
        c1_d = i3_d - d1_q;
        c2_d = c1_d - d2_q;
        c3_d = c2_d - d3_q;
        s_d  = c3_d >>> SHIFT;
        if (s_d > S_MAX) begin
            sat_d = S_MAX[OUT_WIDTH-1:0];
        end else if (s_d < S_MIN) begin
            sat_d = S_MIN[OUT_WIDTH-1:0];
        end else begin
            sat_d = s_d[OUT_WIDTH-1:0];
        end
    end

    // Integrators and decimation counter advance only on input strobes; wrap is cancelled by the combs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1_q  <= '0;
            i2_q  <= '0;
            i3_q  <= '0;
            cnt_q <= '0;
        end else if (pdm_en) begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            i3_q  <= i3_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Comb delay registers capture the previous decimated values on each tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
        end else if (tick) begin
            d1_q <= i3_d;
            d2_q <= c1_d;
            d3_q <= c2_d;
        end
    end

    // Output register with warm-up gating: the first three ticks update pcm_out silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
            settled_q   <= 1'b0;
            warm_q      <= 2'd0;
        end else begin
            pcm_valid_q <= tick && (warm_q == 2'd3);
            if (tick) begin
                pcm_q <= sat_d;
                if (warm_q != 2'd3) begin
                    warm_q <= warm_q + 2'd1;
                end else begin
                    settled_q <= 1'b1;
                end
            end
        end
    end

    assign pcm_out   = pcm_q;
    assign pcm_valid = pcm_valid_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// tb/tb_pdm_decimator.sv - directed self-checking bench for pdm_decimator
module tb_pdm_decimator;

    logic               clk;
    logic               reset;
    logic               pdm_in;
    logic               pdm_en;
    logic signed [15:0] pcm_out;
    logic               pcm_valid;
    logic               settled;

    int checks;
    int errors;
    int clk_cnt;
    int strobe_idx;
    int vcount;
    int first_valid;
    int last_valid_clk;
    int prev_valid_clk;
    int exp_out;
    int gap_valids;
    int held_bad;
    int saved_out;

    pdm_decimator #(.DECIM_LOG2(6), .OUT_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .pdm_in    (pdm_in),
        .pdm_en    (pdm_en),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .settled   (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) clk_cnt <= clk_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        strobe_idx     = 0;
        vcount         = 0;
        first_valid    = -1;
        last_valid_clk = 0;
        prev_valid_clk = 0;
        gap_valids     = 0;
    endtask

    task automatic sync_reset();
        @(negedge clk);
        reset  = 1'b1;
        pdm_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
    endtask

    // n strobes, pattern bit chosen by global strobe index; gap idle clocks before each strobe.
    task automatic feed(input string tag, input int n, input logic [3:0] pat,
                        input int plen, input int gap);
        logic [3:0] p;
        p = pat;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                pdm_en = 1'b0;
                @(posedge clk);
                #1;
                if (pcm_valid) gap_valids++;
            end
            @(negedge clk);
            pdm_en = 1'b1;
            pdm_in = p[strobe_idx % plen];
            @(posedge clk);
            #1;
            strobe_idx++;
            if (pcm_valid) begin
                vcount++;
                if (vcount == 1) first_valid = strobe_idx;
                prev_valid_clk = last_valid_clk;
                last_valid_clk = clk_cnt;
                check(tag, int'(pcm_out), exp_out);
            end
        end
        @(negedge clk);
        pdm_en = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clk_cnt = 0;
        reset   = 1'b1;
        pdm_en  = 1'b0;
        pdm_in  = 1'b0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pcm_out", int'(pcm_out), 0);
        check("rst_valid", int'(pcm_valid), 0);
        check("rst_settled", int'(settled), 0);
        @(negedge clk);
        reset = 1'b0;

        // Constant ones: tick 1 output is I3(64)=45760 >>> 3 = 5720, no valid during warm-up.
        exp_out = 32767;
        feed("ones_out", 64, 4'b1111, 1, 0);
        check("ones_tick1_out", int'(pcm_out), 5720);
        check("ones_tick1_novalid", vcount, 0);
        feed("ones_out", 191, 4'b1111, 1, 0);
        check("ones_pre_settled", int'(settled), 0);
        check("ones_warm_novalid", vcount, 0);
        feed("ones_out", 1, 4'b1111, 1, 0);
        check("ones_first_valid_idx", first_valid, 256);
        check("ones_settled", int'(settled), 1);
        feed("ones_out", 128, 4'b1111, 1, 0);
        check("ones_valid_count", vcount, 3);
        check("ones_period", last_valid_clk - prev_valid_clk, 64);

        // Long idle gap: output holds, no pulses, then stream resumes.
        saved_out = int'(pcm_out);
        held_bad  = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (pcm_valid) gap_valids++;
            if (int'(pcm_out) != saved_out) held_bad++;
        end
        check("gap_no_valid", gap_valids, 0);
        check("gap_out_held", held_bad, 0);
        feed("gap_resume_out", 64, 4'b1111, 1, 0);
        check("gap_resume_count", vcount, 4);

        // Asynchronous reset between edges clears outputs without a clock edge.
        feed("ones_out", 30, 4'b1111, 1, 0);
        check("pre_async_out", int'(pcm_out), 32767);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_pcm_out", int'(pcm_out), 0);
        check("async_valid", int'(pcm_valid), 0);
        check("async_settled", int'(settled), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_stats();

        // Constant zeros after reset: full negative scale, first valid on 4th tick again.
        exp_out = -32768;
        feed("zeros_out", 255, 4'b0000, 1, 0);
        check("zeros_warm_novalid", vcount, 0);
        feed("zeros_out", 65, 4'b0000, 1, 0);
        check("zeros_first_valid_idx", first_valid, 256);
        check("zeros_valid_count", vcount, 2);

        // Alternating 1,0 averages to exactly zero.
        sync_reset();
        exp_out = 0;
        feed("alt_out", 320, 4'b0101, 4, 0);
        check("alt_valid_count", vcount, 2);

        // 1,1,1,0 -> mean +0.5 -> 16384.
        sync_reset();
        exp_out = 16384;
        feed("p1110_out", 320, 4'b0111, 4, 0);
        check("p1110_valid_count", vcount, 2);

        // 1,0,0,0 -> mean -0.5 -> -16384.
        sync_reset();
        exp_out = -16384;
        feed("p1000_out", 320, 4'b0001, 4, 0);
        check("p1000_valid_count", vcount, 2);

        // Strobe every 4th clock: valid period becomes 4*64 clocks.
        sync_reset();
        exp_out = 32767;
        feed("slow_out", 320, 4'b1111, 1, 3);
        check("slow_first_valid_idx", first_valid, 256);
        check("slow_valid_count", vcount, 2);
        check("slow_period", last_valid_clk - prev_valid_clk, 256);
        check("slow_gap_novalid", gap_valids, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
